// File: rtl/riscboy_ppu_pram_sched_pkg.sv
// Shared PPU definitions for the palette RAM write scheduler.
// Holds the default palette geometry, the block-loader FSM state
// encoding and the round-robin turn encoding (HOST = 0, LOAD = 1).
package riscboy_ppu_pram_sched_pkg;

  localparam int unsigned W_PIXDATA_DEF     = 15;
  localparam int unsigned W_PALETTE_IDX_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } ld_state_t;

  typedef enum logic {
    TURN_HOST = 1'b0,
    TURN_LOAD = 1'b1
  } turn_t;

endpackage

// File: rtl/riscboy_ppu_rr_arb2.sv
// Two-requester round-robin arbiter with a global enable.
// Requester A maps to TURN_HOST, requester B to TURN_LOAD.
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   en             global grant enable (no ready while low)
//   req_a, req_b   request valids
//   elig_b         B may be granted at all this cycle
//   rdy_a, rdy_b   readies; neither depends on its own request
//   gnt_a, gnt_b   completed handshakes (req && rdy)
// The turn only flips after a grant made while both sides requested.
module riscboy_ppu_rr_arb2
  import riscboy_ppu_pram_sched_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic req_a,
  input  logic req_b,
  input  logic elig_b,
  output logic rdy_a,
  output logic rdy_b,
  output logic gnt_a,
  output logic gnt_b
);

  turn_t turn_q;

  always_comb begin
    rdy_a = en && (!req_b || (turn_q == TURN_HOST));
    rdy_b = en && elig_b && (!req_a || (turn_q == TURN_LOAD));
    gnt_a = req_a && rdy_a;
    gnt_b = req_b && rdy_b;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      turn_q <= TURN_HOST;
    end else if (req_a && req_b && (gnt_a || gnt_b)) begin
      turn_q <= (turn_q == TURN_HOST) ? TURN_LOAD : TURN_HOST;
    end
  end

endmodule

// File: rtl/riscboy_ppu_pram_sched.sv
// PPU palette RAM write-port scheduler.
// Shares the single PRAM write port between host single-word writes and
// a block palette loader streaming consecutive entries from a base index.
// Writes are only granted while `safe` (blanking) is high.
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   safe                      PPU in blanking; grants allowed only while high
//   cpu_wvld/wrdy/waddr/wdata host write handshake
//   ld_start/base/count/abort block load control
//   ld_vld/rdy/data           loader stream handshake
//   ld_busy, ld_done          load active / one-cycle completion pulse
//   pram_waddr/wdata/wen      registered PRAM write port
module riscboy_ppu_pram_sched
  import riscboy_ppu_pram_sched_pkg::*;
#(
  parameter int unsigned W_PIXDATA     = W_PIXDATA_DEF,
  parameter int unsigned W_PALETTE_IDX = W_PALETTE_IDX_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     safe,
  input  logic                     cpu_wvld,
  output logic                     cpu_wrdy,
  input  logic [W_PALETTE_IDX-1:0] cpu_waddr,
  input  logic [W_PIXDATA-1:0]     cpu_wdata,
  input  logic                     ld_start,
  input  logic [W_PALETTE_IDX-1:0] ld_base,
  input  logic [W_PALETTE_IDX:0]   ld_count,
  input  logic                     ld_abort,
  input  logic                     ld_vld,
  output logic                     ld_rdy,
  input  logic [W_PIXDATA-1:0]     ld_data,
  output logic                     ld_busy,
  output logic                     ld_done,
  output logic [W_PALETTE_IDX-1:0] pram_waddr,
  output logic [W_PIXDATA-1:0]     pram_wdata,
  output logic                     pram_wen
);

  ld_state_t                  state_q, state_d;
  logic [W_PALETTE_IDX-1:0]   ptr_q, ptr_d;
  logic [W_PALETTE_IDX:0]     remaining_q, remaining_d;
  logic                       zero_done_q, zero_done_d;
  logic                       ld_req;
  logic                       gnt_host, gnt_load;

  assign ld_req = (state_q == ST_LOAD) && ld_vld;

  riscboy_ppu_rr_arb2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .en     (safe),
    .req_a  (cpu_wvld),
    .req_b  (ld_req),
    .elig_b ((state_q == ST_LOAD) && !ld_abort),
    .rdy_a  (cpu_wrdy),
    .rdy_b  (ld_rdy),
    .gnt_a  (gnt_host),
    .gnt_b  (gnt_load)
  );

  // A zero-length load never enters LOAD; its done pulse comes from a
  // separate flag so ld_done still lands one cycle after ld_start.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    remaining_d = remaining_q;
    zero_done_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (ld_start && !ld_abort) begin
          if (ld_count == '0) begin
            zero_done_d = 1'b1;
          end else begin
            state_d     = ST_LOAD;
            ptr_d       = ld_base;
            remaining_d = ld_count;
          end
        end
      end
      ST_LOAD: begin
        if (gnt_load) begin
          ptr_d       = ptr_q + 1'b1;
          remaining_d = remaining_q - 1'b1;
          if (remaining_q == (W_PALETTE_IDX + 1)'(1)) begin
            state_d = ST_DONE;
          end
        end
        if (ld_abort) begin
          state_d = ST_IDLE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      remaining_q <= '0;
      zero_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      remaining_q <= remaining_d;
      zero_done_q <= zero_done_d;
    end
  end

  assign ld_busy = (state_q == ST_LOAD);
  assign ld_done = (state_q == ST_DONE) || zero_done_q;

  // The arbiter guarantees at most one grant, so the priority here is moot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pram_wen   <= 1'b0;
      pram_waddr <= '0;
      pram_wdata <= '0;
    end else begin
      pram_wen <= gnt_host || gnt_load;
      if (gnt_host) begin
        pram_waddr <= cpu_waddr;
        pram_wdata <= cpu_wdata;
      end else if (gnt_load) begin
        pram_waddr <= ptr_q;
        pram_wdata <= ld_data;
      end
    end
  end

endmodule
